// File: rtl/prbs_checker.sv
// Serial PRBS checker: seeds a local XNOR LFSR from the line, verifies the prediction,
// then free-runs (flywheel) while locked and counts bit errors.
module prbs_checker #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned X1       = 7,
  parameter int unsigned X2       = 5,
  parameter int unsigned X3       = 4,
  parameter int unsigned X4       = 3,
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned LOSS_CNT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_cnt,
  output logic             locked,
  output logic [1:0]       state,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int unsigned SW = $clog2(WIDTH + 1);
  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned LW = $clog2(LOSS_CNT + 1);

  localparam logic [SW-1:0] SeedMax = SW'(WIDTH);
  localparam logic [MW-1:0] LockMax = MW'(LOCK_CNT);
  localparam logic [LW-1:0] LossMax = LW'(LOSS_CNT);

  typedef enum logic [1:0] {
    StSeed   = 2'd0,
    StVerify = 2'd1,
    StLocked = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [SW-1:0]    seed_cnt_q;
  logic [MW-1:0]    match_cnt_q;
  logic [LW-1:0]    consec_err_q;
  logic             locked_q;
  logic             err_pulse_q;
  logic [CNT_W-1:0] err_count_q;
  logic [CNT_W-1:0] bit_count_q;

  logic             pred;
  logic             mismatch;
  logic [WIDTH-1:0] sr_in;
  logic [WIDTH-1:0] sr_pred;
  logic [SW-1:0]    seed_inc;
  logic [MW-1:0]    match_inc;
  logic [LW-1:0]    consec_inc;
  logic [CNT_W-1:0] err_inc;
  logic [CNT_W-1:0] bit_inc;

  always_comb begin
    pred       = ~(sr_q[X1] ^ sr_q[X2] ^ sr_q[X3] ^ sr_q[X4]);
    mismatch   = in_bit != pred;
    sr_in      = {sr_q[WIDTH-2:0], in_bit};
    sr_pred    = {sr_q[WIDTH-2:0], pred};
    seed_inc   = (seed_cnt_q == SeedMax) ? SeedMax : seed_cnt_q + SW'(1);
    match_inc  = match_cnt_q + MW'(1);
    consec_inc = consec_err_q + LW'(1);
    err_inc    = (&err_count_q) ? err_count_q : err_count_q + CNT_W'(1);
    bit_inc    = (&bit_count_q) ? bit_count_q : bit_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StSeed;
      sr_q         <= '0;
      seed_cnt_q   <= '0;
      match_cnt_q  <= '0;
      consec_err_q <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
      bit_count_q  <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (in_valid) begin
        case (state_q)
          StSeed: begin
            sr_q       <= sr_in;
            seed_cnt_q <= seed_inc;
            // All-ones is the XNOR lock-up state; keep seeding until it is flushed.
            if (seed_inc == SeedMax && !(&sr_in)) state_q <= StVerify;
          end
          StVerify: begin
            sr_q <= sr_in;
            if (mismatch) begin
              state_q     <= StSeed;
              seed_cnt_q  <= '0;
              match_cnt_q <= '0;
            end else if (match_inc == LockMax) begin
              state_q     <= StLocked;
              locked_q    <= 1'b1;
              match_cnt_q <= '0;
            end else begin
              match_cnt_q <= match_inc;
            end
          end
          StLocked: begin
            // Flywheel: advance on the prediction so line errors never enter the register.
            sr_q        <= sr_pred;
            bit_count_q <= bit_inc;
            if (mismatch) begin
              err_pulse_q <= 1'b1;
              err_count_q <= err_inc;
              if (consec_inc == LossMax) begin
                state_q      <= StSeed;
                locked_q     <= 1'b0;
                seed_cnt_q   <= '0;
                match_cnt_q  <= '0;
                consec_err_q <= '0;
              end else begin
                consec_err_q <= consec_inc;
              end
            end else begin
              consec_err_q <= '0;
            end
          end
          default: begin
            state_q  <= StSeed;
            locked_q <= 1'b0;
          end
        endcase
      end
      // Placed last so a clear overrides any increment on the same edge.
      if (clr_cnt) begin
        err_count_q <= '0;
        bit_count_q <= '0;
      end
    end
  end

  assign state     = state_q;
  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: one default instance and one with 4-bit counters,
// both fed from a reference XNOR generator.
module tb_prbs_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_bit, clr_cnt;
  logic        locked, err_pulse;
  logic [1:0]  state;
  logic [15:0] err_count, bit_count;
  logic        locked4, err_pulse4;
  logic [1:0]  state4;
  logic [3:0]  err_count4, bit_count4;

  prbs_checker dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .state     (state),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  prbs_checker #(.CNT_W(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .clr_cnt   (clr_cnt),
    .locked    (locked4),
    .state     (state4),
    .err_pulse (err_pulse4),
    .err_count (err_count4),
    .bit_count (bit_count4)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] gen;
  logic       b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference generator: emits the XNOR of its taps and shifts that bit in.
  task automatic next_bit(output logic nb);
    nb  = ~(gen[7] ^ gen[5] ^ gen[4] ^ gen[3]);
    gen = {gen[6:0], nb};
  endtask

  task automatic step(input logic v, input logic d);
    in_valid = v;
    in_bit   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;
    step(1'b0, 1'b0);
    check_eq("rst_state", 32'(state), 0);
    check_eq("rst_locked", 32'(locked), 0);
    check_eq("rst_pulse", 32'(err_pulse), 0);
    check_eq("rst_err", 32'(err_count), 0);
    check_eq("rst_bits", 32'(bit_count), 0);
    reset = 1'b0;

    // Clean stream acquires lock after 16 bits.
    gen = 8'b01011010;
    for (int i = 1; i <= 16; i++) begin
      next_bit(b);
      step(1'b1, b);
      if (i == 7)  check_eq("acq_state7", 32'(state), 0);
      if (i == 8)  check_eq("acq_state8", 32'(state), 1);
      if (i == 15) check_eq("acq_locked15", 32'(locked), 0);
      if (i == 16) begin
        check_eq("acq_state16", 32'(state), 2);
        check_eq("acq_locked16", 32'(locked), 1);
      end
    end
    for (int i = 0; i < 100; i++) begin
      next_bit(b);
      step(1'b1, b);
    end
    check_eq("clean_err", 32'(err_count), 0);
    check_eq("clean_bits", 32'(bit_count), 100);
    check_eq("clean_bits_sat4", 32'(bit_count4), 15);

    // Single line error.
    next_bit(b);
    step(1'b1, ~b);
    check_eq("single_pulse", 32'(err_pulse), 1);
    check_eq("single_err", 32'(err_count), 1);
    check_eq("single_locked", 32'(locked), 1);
    next_bit(b);
    step(1'b1, b);
    check_eq("single_pulse_off", 32'(err_pulse), 0);
    for (int i = 0; i < 20; i++) begin
      next_bit(b);
      step(1'b1, b);
    end
    check_eq("single_err_after", 32'(err_count), 1);
    check_eq("single_locked_after", 32'(locked), 1);
    check_eq("single_bits", 32'(bit_count), 122);

    // Clear while idle, then four consecutive errors drop lock.
    clr_cnt = 1'b1;
    step(1'b0, 1'b0);
    clr_cnt = 1'b0;
    check_eq("clr_err", 32'(err_count), 0);
    check_eq("clr_bits", 32'(bit_count), 0);
    check_eq("clr_state", 32'(state), 2);
    for (int i = 1; i <= 4; i++) begin
      next_bit(b);
      step(1'b1, ~b);
      if (i == 3) check_eq("loss_locked3", 32'(locked), 1);
    end
    check_eq("loss_locked4", 32'(locked), 0);
    check_eq("loss_state4", 32'(state), 0);
    check_eq("loss_err", 32'(err_count), 4);
    check_eq("loss_bits", 32'(bit_count), 4);
    for (int i = 1; i <= 16; i++) begin
      next_bit(b);
      step(1'b1, b);
      if (i == 8)  check_eq("relock_state8", 32'(state), 1);
      if (i == 15) check_eq("relock_locked15", 32'(locked), 0);
      if (i == 16) check_eq("relock_locked16", 32'(locked), 1);
    end
    check_eq("relock_err_kept", 32'(err_count), 4);

    // Reset mid-lock, then in_valid toggling: junk on invalid cycles must be ignored.
    reset = 1'b1;
    step(1'b1, 1'b1);
    reset = 1'b0;
    check_eq("rst2_state", 32'(state), 0);
    check_eq("rst2_err", 32'(err_count), 0);
    k = 0;
    for (int c = 1; c <= 32; c++) begin
      if (c % 2 == 1) begin
        next_bit(b);
        step(1'b1, b);
        k++;
      end else begin
        step(1'b0, 1'($urandom_range(1, 0)));
        check_eq("tog_pulse", 32'(err_pulse), 0);
      end
      check_eq("tog_state", 32'(state), (k < 8) ? 0 : (k < 16) ? 1 : 2);
    end
    check_eq("tog_locked", 32'(locked), 1);

    // All-ones input is the lock-up pattern and must never seed.
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1);
      check_eq("ones_state", 32'(state), 0);
    end
    check_eq("ones_locked", 32'(locked), 0);

    // Alternating errors keep lock; 4-bit counters saturate.
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      next_bit(b);
      step(1'b1, b);
    end
    check_eq("alt_locked_start", 32'(locked4), 1);
    for (int i = 0; i < 40; i++) begin
      next_bit(b);
      step(1'b1, (i % 2 == 1) ? ~b : b);
    end
    check_eq("alt_locked4", 32'(locked4), 1);
    check_eq("alt_err_sat4", 32'(err_count4), 15);
    check_eq("alt_err16", 32'(err_count), 20);
    check_eq("alt_bits16", 32'(bit_count), 40);
    check_eq("alt_bits_sat4", 32'(bit_count4), 15);
    clr_cnt = 1'b1;
    next_bit(b);
    step(1'b1, ~b);
    clr_cnt = 1'b0;
    check_eq("clrwin_err4", 32'(err_count4), 0);
    check_eq("clrwin_bits4", 32'(bit_count4), 0);
    check_eq("clrwin_err16", 32'(err_count), 0);
    check_eq("clrwin_bits16", 32'(bit_count), 0);
    for (int i = 0; i < 3; i++) begin
      next_bit(b);
      step(1'b1, ~b);
    end
    reset = 1'b1;
    clr_cnt = 1'b0;
    next_bit(b);
    step(1'b1, ~b);
    reset = 1'b0;
    check_eq("rst3_locked4", 32'(locked4), 0);
    check_eq("rst3_state4", 32'(state4), 0);
    check_eq("rst3_pulse4", 32'(err_pulse4), 0);
    check_eq("rst3_err4", 32'(err_count4), 0);
    check_eq("rst3_bits4", 32'(bit_count4), 0);
    check_eq("rst3_locked16", 32'(locked), 0);
    check_eq("rst3_err16", 32'(err_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
